clock_time_ctrl: RTL
====================

# clock_time_ctrl

Time-keeping controller for the century clock. It sequences the seconds, minutes and hours BCD fields from a 1 Hz strobe, cascading carries between fields. It owns a user set-mode state machine driven by two button pulses. It emits a one-cycle day-carry strobe that downstream day/year digit counters use as their enable.

## Interface
Parameters:
- RESET_HOUR, 8'h00, BCD hour loaded on reset (legal 8'h00–8'h23)
- RESET_MIN, 8'h00, BCD minute loaded on reset (legal 8'h00–8'h59)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset; highest priority
- tick_1hz  in  1  one-cycle strobe, once per second
- btn_mode  in  1  debounced one-cycle pulse, advances set mode
- btn_inc  in  1  debounced one-cycle pulse, increments selected field
- sec_bcd  out  8  seconds, two BCD digits, 00–59
- min_bcd  out  8  minutes, two BCD digits, 00–59
- hour_bcd  out  8  hours, two BCD digits, 00–23
- mode  out  2  0 RUN, 1 SET_HH, 2 SET_MM, 3 SET_SS
- day_carry  out  1  one-cycle pulse on the 23:59:59→00:00:00 rollover in RUN

## Operation
- Reset values: sec_bcd 8'h00, min_bcd RESET_MIN, hour_bcd RESET_HOUR, mode RUN, day_carry 0.
- The state at the start of the cycle selects the action. A mode change never affects inputs sampled in the same cycle.
- FSM transitions, on btn_mode only: RUN→SET_HH→SET_MM→SET_SS→RUN. No other transitions exist.
- RUN, on tick_1hz:
  - sec increments.
  - At 59, sec wraps to 00 and min increments.
  - At min 59 with sec wrap, min wraps and hour increments.
  - At hour 23 with min and sec wrap, hour wraps to 00 and day_carry pulses.
- RUN: btn_inc is ignored.
- SET_xx: tick_1hz is ignored and time is frozen.
- SET_xx, on btn_inc: the selected field increments and wraps within its own range (59→00, 23→00). There is no carry into other fields, and day_carry is never asserted.
- Entering SET_SS does not clear seconds. Leaving SET_SS resumes counting from the current value on the next tick.
- btn_mode and btn_inc in the same cycle:
  - The increment applies per the current state.
  - The mode then advances.
  - Example: in SET_MM with both pulses, minutes increment and mode becomes SET_SS.
- btn_mode and tick_1hz in the same cycle while in RUN: the tick is applied and mode becomes SET_HH.
- btn_mode and tick_1hz in the same cycle while in SET_SS: the tick is dropped and mode becomes RUN.
- BCD arithmetic:
  - Low nibble 9→0 carries into the high nibble.
  - Fields never hold non-BCD or out-of-range values.
  - An illegal parameter value must be rejected by an elaboration-time check.

## Timing
- Every output is registered. A field updates on the edge that samples tick_1hz or btn_inc, so values are visible the next cycle (latency 1).
- day_carry is high for exactly the one cycle in which the fields read 00:00:00 after the rollover.
- mode updates on the edge that samples btn_mode.
- reset asserted mid-count or mid-set:
  - Outputs take reset values on that edge.
  - Any tick or button pulse in the same cycle is discarded.
- Back-to-back ticks on consecutive cycles must each advance time by one second. There is no internal rate limiting.

## Structure
- Shared package clock_pkg holds:
  - the mode_t enum (RUN, SET_HH, SET_MM, SET_SS)
  - the constants SEC_MAX 8'h59, MIN_MAX 8'h59, HOUR_MAX 8'h23
- One sub-module, bcd_field_counter:
  - parameter MAX; inputs inc and load; output wrap
  - 8-bit BCD value that increments on inc, wraps at MAX, and asserts wrap combinationally when inc is high at MAX
- Instantiate bcd_field_counter three times. The top level only gates the inc inputs from the FSM state and the cascaded wraps, and registers day_carry.

## Test plan
- Reset with RESET_HOUR 8'h12, RESET_MIN 8'h30: after reset, hour 8'h12, min 8'h30, sec 8'h00, mode 0, day_carry 0.
- Preset 23:59:58 in RUN, two ticks: 23:59:59, then 00:00:00 with day_carry high for one cycle only.
- Field cascade: from 00:09:59, one tick gives 00:10:00; from 09:59:59, one tick gives 10:00:00 (BCD nibble carry).
- btn_mode once, then btn_inc 25 times in SET_HH from hour 8'h00: hour reads 8'h01 (wrap at 23). Ten ticks during SET_HH leave all fields unchanged.
- In SET_MM at minute 8'h59, btn_inc and btn_mode in the same cycle: min 8'h00, hour unchanged, mode 3.
- In SET_SS with btn_mode and tick together: mode 0 and seconds unchanged. Assert reset alongside a tick in RUN: all fields at reset values and day_carry 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types, field limits and BCD helpers for the century clock time-keeping logic.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SET_HH = 2'd1,
      SET_MM = 2'd2,
      SET_SS = 2'd3
   } mode_t;

   localparam logic [7:0] SEC_MAX  = 8'h59;
   localparam logic [7:0] MIN_MAX  = 8'h59;
   localparam logic [7:0] HOUR_MAX = 8'h23;

   // Valid BCD ordering matches binary ordering, so a plain compare bounds the range.
   function automatic logic bcd_legal(input logic [7:0] value, input logic [7:0] max);
      return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max);
   endfunction

   function automatic logic [7:0] bcd_next(input logic [7:0] value, input logic [7:0] max);
      logic [7:0] result;
      if (value >= max) begin
         result = 8'h00;
      end else if (value[3:0] >= 4'd9) begin
         result = {value[7:4] + 4'd1, 4'd0};
      end else begin
         result = {value[7:4], value[3:0] + 4'd1};
      end
      return result;
   endfunction

endpackage

// File: rtl/clock_time_ctrl_bcd_field_counter.sv
// Two-digit BCD field that counts 00..MAX and flags the wrap combinationally.
module bcd_field_counter
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX  = 8'h59,
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic       clk,
   input  logic       load,
   input  logic       inc,
   output logic [7:0] value,
   output logic       wrap
);

   logic [7:0] value_q;
   logic [7:0] value_d;

   if (!bcd_legal(INIT, MAX)) begin : g_bad_init
      $error("bcd_field_counter: INIT is not a legal BCD value within 00..MAX");
   end

   // load restores INIT and wins over inc so a reset cycle drops any pending increment.
   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = INIT;
      end else if (inc) begin
         value_d = bcd_next(value_q, MAX);
      end
   end

   always_ff @(posedge clk) begin
      value_q <= value_d;
   end

   assign value = value_q;
   assign wrap  = inc && (value_q == MAX);

endmodule

// File: rtl/clock_time_ctrl.sv
// Seconds/minutes/hours sequencing, button-driven set mode and day-carry strobe.
module clock_time_ctrl
   import clock_pkg::*;
#(
   parameter logic [7:0] RESET_HOUR = 8'h00,
   parameter logic [7:0] RESET_MIN  = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] hour_bcd,
   output logic [1:0] mode,
   output logic       day_carry
);

   mode_t mode_q;
   mode_t mode_d;
   logic  day_carry_q;
   logic  day_carry_d;

   logic  sec_inc;
   logic  min_inc;
   logic  hour_inc;
   logic  sec_wrap;
   logic  min_wrap;
   logic  hour_wrap;

   if (!bcd_legal(RESET_HOUR, HOUR_MAX)) begin : g_bad_reset_hour
      $error("clock_time_ctrl: RESET_HOUR must be BCD 00..23");
   end
   if (!bcd_legal(RESET_MIN, MIN_MAX)) begin : g_bad_reset_min
      $error("clock_time_ctrl: RESET_MIN must be BCD 00..59");
   end

   // The current mode alone decides which field moves; a btn_mode in the same
   // cycle only changes the mode seen from the next cycle onward.
   always_comb begin
      sec_inc     = 1'b0;
      min_inc     = 1'b0;
      hour_inc    = 1'b0;
      day_carry_d = 1'b0;
      mode_d      = mode_q;

      unique case (mode_q)
         RUN: begin
            sec_inc     = tick_1hz;
            min_inc     = sec_wrap;
            hour_inc    = min_wrap;
            day_carry_d = hour_wrap;
         end
         SET_HH:  hour_inc = btn_inc;
         SET_MM:  min_inc  = btn_inc;
         SET_SS:  sec_inc  = btn_inc;
         default: ;
      endcase

      if (btn_mode) begin
         unique case (mode_q)
            RUN:     mode_d = SET_HH;
            SET_HH:  mode_d = SET_MM;
            SET_MM:  mode_d = SET_SS;
            SET_SS:  mode_d = RUN;
            default: mode_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q      <= RUN;
         day_carry_q <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         day_carry_q <= day_carry_d;
      end
   end

   bcd_field_counter #(
      .MAX  (SEC_MAX),
      .INIT (8'h00)
   ) u_sec (
      .clk   (clk),
      .load  (reset),
      .inc   (sec_inc),
      .value (sec_bcd),
      .wrap  (sec_wrap)
   );

   bcd_field_counter #(
      .MAX  (MIN_MAX),
      .INIT (RESET_MIN)
   ) u_min (
      .clk   (clk),
      .load  (reset),
      .inc   (min_inc),
      .value (min_bcd),
      .wrap  (min_wrap)
   );

   bcd_field_counter #(
      .MAX  (HOUR_MAX),
      .INIT (RESET_HOUR)
   ) u_hour (
      .clk   (clk),
      .load  (reset),
      .inc   (hour_inc),
      .value (hour_bcd),
      .wrap  (hour_wrap)
   );

   assign mode      = mode_q;
   assign day_carry = day_carry_q;

endmodule
